// File: rtl/reg_write_demux.sv
// Write-side steering for a 32-entry register file with a sequenced bulk clear.
// Every entry is exposed on a flat bus that feeds the matching 32:1 read mux.
module reg_write_demux #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          ZERO_ENTRY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_sel,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic [31:0]           we_onehot,
  output logic [32*WIDTH-1:0]   dout_flat
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Entry 0 is never written from the write port when it is hard-wired to zero;
  // its storage then stays at its reset value forever.
  localparam logic [31:0] WR_MASK = ZERO_ENTRY ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;

  state_t           state;
  state_t           state_next;
  logic [4:0]       clr_idx;
  logic [4:0]       clr_idx_next;
  logic [31:0]      we_next;
  logic             clr_done_next;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] entries [32];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    clr_idx_next  = clr_idx;
    we_next       = '0;
    clr_done_next = 1'b0;
    wdata         = wr_data;
    wr_ready      = 1'b0;
    clr_busy      = 1'b0;

    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          we_next = WR_MASK & (32'd1 << wr_sel);
        end
        if (clr_req) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      CLEAR: begin
        clr_busy     = 1'b1;
        wdata        = '0;
        we_next      = 32'd1 << clr_idx;
        clr_idx_next = clr_idx + 5'd1;
        if (clr_idx == 5'd31) begin
          state_next    = IDLE;
          clr_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_idx   <= '0;
      we_onehot <= '0;
      clr_done  <= 1'b0;
    end else begin
      state     <= state_next;
      clr_idx   <= clr_idx_next;
      we_onehot <= we_next;
      clr_done  <= clr_done_next;
    end
  end

  // NOTE: the storage array is reset deliberately: every entry must read zero
  // straight out of reset, so this is flop storage, not an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        entries[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (we_next[i]) begin
          entries[i] <= wdata;
        end
      end
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_out
    assign dout_flat[i*WIDTH +: WIDTH] = entries[i];
  end

endmodule

// File: tb/tb_reg_write_demux.sv
// Self-checking bench for reg_write_demux: directed vector table, multi-cycle
// clear sequences, and random traffic against a queue-free array model.
module tb_reg_write_demux;

  logic           clk;
  logic           rst_n;
  logic           wr_valid;
  logic           wr_ready;
  logic [4:0]     wr_sel;
  logic [31:0]    wr_data;
  logic           clr_req;
  logic           clr_busy;
  logic           clr_done;
  logic [31:0]    we_onehot;
  logic [1023:0]  dout_flat;

  reg_write_demux #(.WIDTH(32), .ZERO_ENTRY(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .we_onehot (we_onehot),
    .dout_flat (dout_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: entry contents, clear position (-1 = not clearing),
  // and the strobe / done values expected after the most recent edge.
  logic [31:0] m_ent [32];
  int          clr_pos;
  logic [31:0] m_we;
  logic        m_done;

  typedef struct {
    logic        v;
    logic [4:0]  sel;
    logic [31:0] data;
    logic [31:0] exp_we;
    logic [31:0] exp_entry;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] entry(input int i);
    return dout_flat[i*32 +: 32];
  endfunction

  task automatic check_bus();
    int bad;
    bad = -1;
    for (int i = 0; i < 32; i++) begin
      if (bad < 0 && entry(i) !== m_ent[i]) bad = i;
    end
    total++;
    if (bad < 0) passed++;
    else $display("FAIL dout_flat entry %0d: got %h expected %h", bad, entry(bad), m_ent[bad]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_ent[i] = '0;
    clr_pos = -1;
    m_we    = '0;
    m_done  = 1'b0;
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_step();
    m_we   = '0;
    m_done = 1'b0;
    if (clr_pos < 0) begin
      if (wr_valid && wr_sel != 5'd0) begin
        m_ent[wr_sel] = wr_data;
        m_we[wr_sel]  = 1'b1;
      end
      if (clr_req) clr_pos = 0;
    end else begin
      m_ent[clr_pos] = '0;
      m_we[clr_pos]  = 1'b1;
      clr_pos++;
      if (clr_pos == 32) begin
        clr_pos = -1;
        m_done  = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("wr_ready", wr_ready, (clr_pos < 0));
    check("clr_busy", clr_busy, (clr_pos >= 0));
    check("clr_done", clr_done, m_done);
    check("we_onehot", we_onehot, m_we);
    check_bus();
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    wr_valid = 1'b0;
    wr_sel   = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int ready_low_cnt;
    int done_cnt;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h0000_0020, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd1,  32'h1111_1111, 32'h0000_0002, 32'h1111_1111};
    vecs[2] = '{1'b1, 5'd2,  32'h2222_2222, 32'h0000_0004, 32'h2222_2222};
    vecs[3] = '{1'b1, 5'd31, 32'h3333_3333, 32'h8000_0000, 32'h3333_3333};
    vecs[4] = '{1'b1, 5'd0,  32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{1'b0, 5'd5,  32'hFFFF_FFFF, 32'h0000_0000, 32'hDEADBEEF};

    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // Reset state
    #12;
    check("reset we_onehot", we_onehot, 32'h0);
    check("reset clr_busy", clr_busy, 1'b0);
    check("reset clr_done", clr_done, 1'b0);
    check_bus();
    rst_n = 1'b1;
    #1;
    check("ready after reset", wr_ready, 1'b1);
    cycle();

    // Directed vector table: single write, back-to-back writes, zero entry, idle
    for (int k = 0; k < 6; k++) begin
      wr_valid = vecs[k].v;
      wr_sel   = vecs[k].sel;
      wr_data  = vecs[k].data;
      cycle();
      check($sformatf("vec%0d we_onehot", k), we_onehot, vecs[k].exp_we);
      check($sformatf("vec%0d entry", k), entry(vecs[k].sel), vecs[k].exp_entry);
    end
    idle_inputs();

    // Fill every entry, then run a full clear with stray requests and writes
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1'b1;
      wr_sel   = 5'(i);
      wr_data  = $urandom | 32'h1;
      cycle();
    end
    idle_inputs();
    busy_cnt = 0;
    ready_low_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 34; k++) begin
      clr_req  = (k < 5);
      wr_valid = (k >= 10 && k < 16);
      wr_sel   = 5'd20;
      wr_data  = $urandom;
      cycle();
      if (clr_busy) busy_cnt++;
      if (!wr_ready) ready_low_cnt++;
      if (clr_done) done_cnt++;
      if (k >= 1 && k <= 32) check("clear walk", we_onehot, 32'd1 << (k - 1));
    end
    idle_inputs();
    check("clear busy cycles", busy_cnt, 32);
    check("clear ready low cycles", ready_low_cnt, 32);
    check("clear done pulses", done_cnt, 1);
    check("entry 31 cleared", entry(31), 32'h0);

    // Write and clear request on the same edge
    wr_valid = 1'b1;
    wr_sel   = 5'd7;
    wr_data  = 32'hA5A5_A5A5;
    clr_req  = 1'b1;
    cycle();
    idle_inputs();
    check("same-edge write kept", entry(7), 32'hA5A5_A5A5);
    for (int j = 0; j < 32; j++) begin
      cycle();
      check($sformatf("entry7 at step %0d", j), entry(7), (j >= 7) ? 32'h0 : 32'hA5A5_A5A5);
    end
    cycle();

    // Reset asserted in the middle of a clear
    for (int i = 1; i < 32; i += 3) begin
      wr_valid = 1'b1;
      wr_sel   = 5'(i);
      wr_data  = $urandom;
      cycle();
    end
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int j = 0; j < 10; j++) cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midclear reset we_onehot", we_onehot, 32'h0);
    check("midclear reset clr_busy", clr_busy, 1'b0);
    check("midclear reset clr_done", clr_done, 1'b0);
    check_bus();
    #2 rst_n = 1'b1;
    #1;
    check("ready after midclear reset", wr_ready, 1'b1);
    done_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      cycle();
      if (clr_done) done_cnt++;
    end
    check("no done after aborted clear", done_cnt, 0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_sel   = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      clr_req  = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle_inputs();
    for (int j = 0; j < 34; j++) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
